sar_logic_param: RTL

SAR_LOGIC_PARAM -- requirements
Module: sar_logic_param

---
 rtl/sar_pkg.sv | 35 +++
 rtl/sar_logic_param_if.sv | 36 +++
 rtl/sar_phase_timer.sv | 31 +++
 rtl/sar_logic_param.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/sar_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sar_pkg : shared state encoding, parameter defaults and width helpers |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package sar_pkg;

  localparam int unsigned DEF_BIT_ADC    = 6;
  localparam int unsigned DEF_SAMPLE_CYC = 2;
  localparam int unsigned DEF_SETTLE_CYC = 2;
  localparam int unsigned DEF_COMP_CYC   = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SAMPLE = 3'd1,
    S_SETTLE = 3'd2,
    S_COMP   = 3'd3,
    S_DECIDE = 3'd4,
    S_DONE   = 3'd5
  } sar_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Phase counter is loaded with (cycles-1), so it must hold max_cyc-1.
  function automatic int unsigned cnt_width(input int unsigned max_cyc);
    return (max_cyc < 2) ? 1 : $clog2(max_cyc);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sar_logic_param_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sar_logic_param_if : control, CDAC and result bus of the SAR logic    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface sar_logic_param_if
  import sar_pkg::*;
#(
  parameter int unsigned BIT_ADC = DEF_BIT_ADC
) ();

  logic               START;
  logic               CONT;
  logic               COMP_OUT;
  logic               RD_ACK;
  logic               COMP_CLK;
  logic               SC;
  logic [BIT_ADC:0]   SDAC;
  logic [BIT_ADC-1:0] DOUT;
  logic               DOUT_VALID;
  logic               EOC;
  logic               BUSY;
  logic               OVR;

  modport slave (
    input  START, CONT, COMP_OUT, RD_ACK,
    output COMP_CLK, SC, SDAC, DOUT, DOUT_VALID, EOC, BUSY, OVR
  );

  modport master (
    output START, CONT, COMP_OUT, RD_ACK,
    input  COMP_CLK, SC, SDAC, DOUT, DOUT_VALID, EOC, BUSY, OVR
  );

endinterface
`default_nettype wire

// File: rtl/sar_phase_timer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sar_phase_timer : loadable down-counter, done when it reaches zero    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sar_phase_timer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] val_i,
  output logic             done_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/sar_logic_param.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | sar_logic_param : successive-approximation control with CDAC drive    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module sar_logic_param
  import sar_pkg::*;
#(
  parameter int unsigned BIT_ADC    = DEF_BIT_ADC,
  parameter int unsigned SAMPLE_CYC = DEF_SAMPLE_CYC,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned COMP_CYC   = DEF_COMP_CYC
) (
  input  logic              CLK,
  input  logic              XRST,
  sar_logic_param_if.slave  bus
);

  localparam int unsigned c_CW = cnt_width(max3(SAMPLE_CYC, SETTLE_CYC, COMP_CYC));
  localparam int unsigned c_KW = (BIT_ADC < 2) ? 1 : $clog2(BIT_ADC);

  localparam logic [c_KW-1:0]    c_K_MSB     = c_KW'(BIT_ADC - 1);
  localparam logic [BIT_ADC-1:0] c_MSB_ONE   = {1'b1, {(BIT_ADC-1){1'b0}}};
  localparam logic [c_CW-1:0]    c_LD_SAMPLE = c_CW'(SAMPLE_CYC - 1);
  localparam logic [c_CW-1:0]    c_LD_SETTLE = c_CW'(SETTLE_CYC - 1);
  localparam logic [c_CW-1:0]    c_LD_COMP   = c_CW'(COMP_CYC - 1);

  sar_state_e         state_q;
  logic [BIT_ADC-1:0] trial_q;
  logic [c_KW-1:0]    k_q;
  logic               sc_q;
  logic               comp_clk_q;
  logic [BIT_ADC-1:0] sdac_q;
  logic [BIT_ADC-1:0] dout_q;
  logic               dout_valid_q;
  logic               eoc_q;
  logic               ovr_q;
  logic               busy_q;

  logic               w_tmr_load;
  logic [c_CW-1:0]    w_tmr_val;
  logic               w_tmr_done;
  logic [c_KW-1:0]    w_km1;
  logic [BIT_ADC-1:0] w_trial_dec;
  logic [BIT_ADC-1:0] w_trial_nxt;

  sar_phase_timer #(
    .WIDTH (c_CW)
  ) u_timer (
    .clk    (CLK),
    .rst_n  (XRST),
    .load_i (w_tmr_load),
    .val_i  (w_tmr_val),
    .done_o (w_tmr_done)
  );

  // Timer is reloaded on the same edge that enters a timed phase.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = c_LD_SAMPLE;
    case (state_q)
      S_IDLE:   w_tmr_load = bus.START | bus.CONT;
      S_SAMPLE: begin
        w_tmr_load = w_tmr_done;
        w_tmr_val  = c_LD_SETTLE;
      end
      S_SETTLE: begin
        w_tmr_load = w_tmr_done;
        w_tmr_val  = c_LD_COMP;
      end
      S_DECIDE: begin
        w_tmr_load = (k_q != '0);
        w_tmr_val  = c_LD_SETTLE;
      end
      S_DONE:   w_tmr_load = bus.CONT;
      default:  w_tmr_load = 1'b0;
    endcase
  end

  assign w_km1 = k_q - c_KW'(1);

  always_comb begin
    w_trial_dec        = trial_q;
    w_trial_dec[k_q]   = bus.COMP_OUT;
    w_trial_nxt        = w_trial_dec;
    w_trial_nxt[w_km1] = 1'b1;
  end

  always_ff @(posedge CLK or negedge XRST) begin
    if (!XRST) begin
      state_q      <= S_IDLE;
      trial_q      <= '0;
      k_q          <= c_K_MSB;
      sc_q         <= 1'b1;
      comp_clk_q   <= 1'b0;
      sdac_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      eoc_q        <= 1'b0;
      ovr_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      eoc_q <= 1'b0;
      if (bus.RD_ACK) begin
        dout_valid_q <= 1'b0;
        ovr_q        <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (bus.START || bus.CONT) begin
            state_q    <= S_SAMPLE;
            busy_q     <= 1'b1;
            sc_q       <= 1'b1;
            comp_clk_q <= 1'b0;
            sdac_q     <= '0;
            trial_q    <= '0;
            k_q        <= c_K_MSB;
          end
        end
        S_SAMPLE: begin
          if (w_tmr_done) begin
            state_q <= S_SETTLE;
            sc_q    <= 1'b0;
            trial_q <= c_MSB_ONE;
            sdac_q  <= c_MSB_ONE;
          end
        end
        S_SETTLE: begin
          if (w_tmr_done) begin
            state_q    <= S_COMP;
            comp_clk_q <= 1'b1;
          end
        end
        S_COMP: begin
          if (w_tmr_done) begin
            state_q    <= S_DECIDE;
            comp_clk_q <= 1'b0;
          end
        end
        S_DECIDE: begin
          if (k_q != '0) begin
            state_q <= S_SETTLE;
            trial_q <= w_trial_nxt;
            sdac_q  <= w_trial_nxt;
            k_q     <= w_km1;
          end else begin
            // An ack landing on the load edge consumes the old word, so no overrun.
            state_q      <= S_DONE;
            trial_q      <= w_trial_dec;
            dout_q       <= w_trial_dec;
            eoc_q        <= 1'b1;
            dout_valid_q <= 1'b1;
            ovr_q        <= bus.RD_ACK ? ovr_q : (ovr_q | dout_valid_q);
            sdac_q       <= '0;
            sc_q         <= 1'b1;
          end
        end
        S_DONE: begin
          if (bus.CONT) begin
            state_q <= S_SAMPLE;
            trial_q <= '0;
            k_q     <= c_K_MSB;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.COMP_CLK   = comp_clk_q;
  assign bus.SC         = sc_q;
  assign bus.SDAC       = {sdac_q, 1'b0};
  assign bus.DOUT       = dout_q;
  assign bus.DOUT_VALID = dout_valid_q;
  assign bus.EOC        = eoc_q;
  assign bus.BUSY       = busy_q;
  assign bus.OVR        = ovr_q;

endmodule
`default_nettype wire
